// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and widths for the fetch-stage PC sequencer
// Contents: PC_W / IDX_W widths, pc_t / idx_t, state_t (IDLE, RUN, BRANCH, HALT), PC_MAX.
package pc_seq_pkg;

  localparam int PC_W  = 11;
  localparam int IDX_W = 6;

  typedef logic [PC_W-1:0]  pc_t;
  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    BRANCH = 2'd2,
    HALT   = 2'd3
  } state_t;

  localparam pc_t PC_MAX = '1;

endpackage

// File: rtl/pc_seq_if.sv
// rtl/pc_seq_if.sv - control, decoder, LUT and fetch signals of the PC sequencer
// master: decoder/control side (drives start, stall, halt, br_*, lut_target)
// slave : pc_sequencer (drives lut_index, pc, fetch_valid, done, pc_wrap)
interface pc_seq_if;
  import pc_seq_pkg::*;

  logic start;
  logic stall;
  logic halt;
  logic br_req;
  logic br_abs;
  idx_t br_idx;
  idx_t lut_index;
  pc_t  lut_target;
  pc_t  pc;
  logic fetch_valid;
  logic done;
  logic pc_wrap;

  modport master (
    output start, stall, halt, br_req, br_abs, br_idx, lut_target,
    input  lut_index, pc, fetch_valid, done, pc_wrap
  );

  modport slave (
    input  start, stall, halt, br_req, br_abs, br_idx, lut_target,
    output lut_index, pc, fetch_valid, done, pc_wrap
  );

endinterface

// File: rtl/pc_seq_cycle_cnt.sv
// rtl/pc_seq_cycle_cnt.sv - saturating cycle counter for the PC sequencer
// Ports: clk, rst_n (async active-low), clr (sync clear), en (count), cnt (CNT_W, saturates at all-ones)
module pc_seq_cycle_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage program counter with halt and LUT-based branches
// Ports: clk, rst_n (async active-low), bus (pc_seq_if.slave: start/stall/halt/br_* in,
//        lut_index out, lut_target in, pc/fetch_valid/done/pc_wrap out),
//        cycle_cnt (CNT_W, only when PC_SEQ_CYCLE_CNT_EN is defined).
// Optional feature macro: PC_SEQ_CYCLE_CNT_EN (RUN/BRANCH cycle counter).
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter pc_t START_PC = '0,
  parameter int  CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  pc_seq_if.slave          bus
`ifdef PC_SEQ_CYCLE_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt
`endif
);

  state_t state_q, state_d;
  pc_t    pc_q, pc_d;
  idx_t   idx_q, idx_d;
  logic   abs_q, abs_d;
  logic   done_q, done_d;
  logic   wrap_q, wrap_d;
  logic   start_ok;

  // start is only honoured when nothing is executing
  assign start_ok = bus.start && ((state_q == IDLE) || (state_q == HALT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      idx_q   <= '0;
      abs_q   <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      idx_q   <= idx_d;
      abs_q   <= abs_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    idx_d   = idx_q;
    abs_d   = abs_q;
    done_d  = done_q;
    wrap_d  = wrap_q;
    if (start_ok) begin
      // covers both IDLE and HALT; start beats a concurrent halt
      state_d = RUN;
      pc_d    = START_PC;
      done_d  = 1'b0;
      wrap_d  = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (!bus.stall) begin
            if (bus.halt) begin
              state_d = HALT;
              done_d  = 1'b1;
            end else if (bus.br_req) begin
              state_d = BRANCH;
              idx_d   = bus.br_idx;
              abs_d   = bus.br_abs;
            end else begin
              pc_d = pc_q + pc_t'(1);
              if (pc_q == PC_MAX) wrap_d = 1'b1;
            end
          end
        end
        BRANCH: begin
          // lut_target is valid this cycle from the registered lut_index
          if (!bus.stall) begin
            state_d = RUN;
            pc_d    = abs_q ? bus.lut_target : (pc_q + bus.lut_target);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pc          = pc_q;
  assign bus.lut_index   = idx_q;
  assign bus.done        = done_q;
  assign bus.pc_wrap     = wrap_q;
  assign bus.fetch_valid = (state_q == RUN) && !bus.stall;

`ifdef PC_SEQ_CYCLE_CNT_EN
  pc_seq_cycle_cnt #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_ok),
    .en    ((state_q == RUN) || (state_q == BRANCH)),
    .cnt   (cycle_cnt)
  );
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed and randomized bench for pc_sequencer
module tb_pc_sequencer;

  localparam int PCMOD   = 2048;
  localparam int TB_CNTW = 4;
  localparam int CNT_MAX = (1 << TB_CNTW) - 1;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_LOOK = 2;
  localparam int M_HALT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_seq_if bus ();

  logic [10:0] lut [64];
  assign bus.lut_target = lut[bus.lut_index];

`ifdef PC_SEQ_CYCLE_CNT_EN
  logic [TB_CNTW-1:0] cycle_cnt;
  pc_sequencer #(.CNT_W(TB_CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .cycle_cnt(cycle_cnt));
`else
  pc_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int m_mode, m_pc, m_idx, m_abs, m_done, m_wrap, m_cnt;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_pc = 0; m_idx = 0; m_abs = 0;
    m_done = 0; m_wrap = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit st, input bit sl, input bit h, input bit b,
                            input bit a, input int idx);
    if ((m_mode == M_IDLE || m_mode == M_HALT) && st) begin
      m_mode = M_RUN; m_pc = 0; m_done = 0; m_wrap = 0; m_cnt = 0;
    end else if (m_mode == M_RUN) begin
      if (m_cnt < CNT_MAX) m_cnt++;
      if (!sl) begin
        if (h) begin
          m_mode = M_HALT; m_done = 1;
        end else if (b) begin
          m_mode = M_LOOK; m_idx = idx; m_abs = a;
        end else begin
          if (m_pc == PCMOD - 1) m_wrap = 1;
          m_pc = (m_pc + 1) % PCMOD;
        end
      end
    end else if (m_mode == M_LOOK) begin
      if (m_cnt < CNT_MAX) m_cnt++;
      if (!sl) begin
        m_pc   = m_abs ? int'(lut[m_idx]) : (m_pc + int'(lut[m_idx])) % PCMOD;
        m_mode = M_RUN;
      end
    end
  endtask

  task automatic check_outputs(input bit sl);
    chk("pc", int'(bus.pc), m_pc);
    chk("fetch_valid", int'(bus.fetch_valid), (m_mode == M_RUN && !sl) ? 1 : 0);
    chk("done", int'(bus.done), m_done);
    chk("pc_wrap", int'(bus.pc_wrap), m_wrap);
    chk("lut_index", int'(bus.lut_index), m_idx);
`ifdef PC_SEQ_CYCLE_CNT_EN
    chk("cycle_cnt", int'(cycle_cnt), m_cnt);
`endif
  endtask

  // one clock: drive inputs at the falling edge, compare, advance the model
  task automatic cyc(input bit st, input bit sl, input bit h, input bit b,
                     input bit a, input int idx);
    @(negedge clk);
    bus.start = st; bus.stall = sl; bus.halt = h;
    bus.br_req = b; bus.br_abs = a; bus.br_idx = 6'(idx);
    #1;
    check_outputs(sl);
    model_step(st, sl, h, b, a, idx);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.start = 0; bus.stall = 0; bus.halt = 0;
    bus.br_req = 0; bus.br_abs = 0; bus.br_idx = '0;
    #1;
    model_reset();
    check_outputs(1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) lut[i] = 11'($urandom_range(0, PCMOD - 1));
    lut[2] = 11'd492;
    lut[3] = 11'd10;
    lut[4] = 11'h7FC;
    lut[5] = 11'd2047;
    model_reset();
    do_reset();

    // mid-run reset at pc=37
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 37; i++) cyc(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("pc_before_reset", int'(bus.pc), 37);
    do_reset();
    chk("reset_fetch_valid", int'(bus.fetch_valid), 0);

    // start, run, stall
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 0, 0);
    @(posedge clk); #1;
    chk("stall_hold_pc", int'(bus.pc), 4);

    // absolute branch
    cyc(0, 0, 0, 1, 1, 2);
    cyc(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("abs_target", int'(bus.pc), 492);

    // to pc=10, then relative -4 with a stalled lookup
    cyc(0, 0, 0, 1, 1, 3);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 4);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("rel_target", int'(bus.pc), 6);

    // halt beats branch, then start beats halt
    cyc(0, 0, 1, 1, 1, 2);
    @(posedge clk); #1;
    chk("halt_done", int'(bus.done), 1);
    chk("halt_pc", int'(bus.pc), 6);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    @(posedge clk); #1;
    chk("restart_pc", int'(bus.pc), 0);
    chk("restart_done", int'(bus.done), 0);

    // increment wrap and counter saturation
    cyc(0, 0, 0, 1, 1, 5);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("wrap_pc", int'(bus.pc), 0);
    chk("wrap_flag", int'(bus.pc_wrap), 1);
    for (int i = 0; i < 20; i++) cyc(0, i[0], 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("wrap_sticky", int'(bus.pc_wrap), 1);
`ifdef PC_SEQ_CYCLE_CNT_EN
    chk("cnt_saturated", int'(cycle_cnt), CNT_MAX);
`endif

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 24) == 0, $urandom_range(0, 4) == 0,
            1'($urandom_range(0, 1)), int'($urandom_range(0, 63)));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
